// File: rtl/exec_pkg.sv
// Shared decode constants and internal ALU control codes for the execute stage.
package exec_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2a;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2b;

    typedef enum logic [4:0] {
        ALU_ZERO, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR,
        ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_LUI, ALU_MFHI, ALU_MFLO, ALU_MULT, ALU_MULTU
    } alu_fn_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle over WIDTH cycles.
// done is high during the last iteration, with the final product on product.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                 running;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;

    always_comb begin
        mag_a    = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b    = (is_signed && b[WIDTH-1]) ? -b : b;
        acc_next = mplier[0] ? (acc + mcand) : acc;
        done     = running && (cnt == '0);
        product  = neg ? -acc_next : acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CNT_W'(WIDTH - 1);
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            acc     <= '0;
            neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (running) begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt - 1'b1;
            if (cnt == '0)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/execute_stage_pipelined.sv
// Registered execute stage: ALU, HI/LO with iterative multiply, valid/ready EX/MEM register.
// state | meaning
// IDLE  | accepting ops; single-cycle results go straight to EX/MEM
// MUL   | multiplier iterating; HI/LO written on its last cycle
// DONE  | waiting for a free EX/MEM slot to emit the LO beat
module execute_stage_pipelined
    import exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_rs_data,
    input  logic [WIDTH-1:0]   in_rt_data,
    input  logic [WIDTH-1:0]   in_imm,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [5:0]         in_funct,
    input  logic [2:0]         in_alu_op,
    input  logic               in_alu_src,
    input  logic               in_wb_en,
    input  logic [4:0]         in_dest,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_overflow,
    output logic               out_wb_en,
    output logic [4:0]         out_dest,
    output logic               busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int MSB = WIDTH - 1;

    logic [1:0]         state, state_next;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   op_a, op_b, sum, diff, res;
    logic               ovf, is_mul, accept, buf_free, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    alu_fn_e            fn;

    assign buf_free = !out_valid || out_ready;
    assign in_ready = (state == S_IDLE) && buf_free;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign is_mul   = (fn == ALU_MULT) || (fn == ALU_MULTU);

    always_comb begin
        fn = ALU_ZERO;
        case (in_alu_op)
            ALUOP_ADD: fn = ALU_ADD;
            ALUOP_SUB: fn = ALU_SUB;
            ALUOP_AND: fn = ALU_AND;
            ALUOP_OR:  fn = ALU_OR;
            ALUOP_SLT: fn = ALU_SLT;
            ALUOP_LUI: fn = ALU_LUI;
            ALUOP_RTYPE: begin
                case (in_funct)
                    FUNCT_ADD:   fn = ALU_ADD;
                    FUNCT_ADDU:  fn = ALU_ADDU;
                    FUNCT_SUB:   fn = ALU_SUB;
                    FUNCT_SUBU:  fn = ALU_SUBU;
                    FUNCT_AND:   fn = ALU_AND;
                    FUNCT_OR:    fn = ALU_OR;
                    FUNCT_XOR:   fn = ALU_XOR;
                    FUNCT_NOR:   fn = ALU_NOR;
                    FUNCT_SLT:   fn = ALU_SLT;
                    FUNCT_SLTU:  fn = ALU_SLTU;
                    FUNCT_SLL:   fn = ALU_SLL;
                    FUNCT_SRL:   fn = ALU_SRL;
                    FUNCT_SRA:   fn = ALU_SRA;
                    FUNCT_MFHI:  fn = ALU_MFHI;
                    FUNCT_MFLO:  fn = ALU_MFLO;
                    FUNCT_MULT:  fn = ALU_MULT;
                    FUNCT_MULTU: fn = ALU_MULTU;
                    default:     fn = ALU_ZERO;
                endcase
            end
            default: fn = ALU_ZERO;
        endcase
    end

    always_comb begin
        op_a = in_rs_data;
        op_b = in_alu_src ? in_rt_data : in_imm;
        sum  = op_a + op_b;
        diff = op_a - op_b;
        res  = '0;
        ovf  = 1'b0;
        case (fn)
            ALU_ADD: begin
                res = sum;
                ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            ALU_SUB: begin
                res = diff;
                ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            ALU_ADDU: res = sum;
            ALU_SUBU: res = diff;
            ALU_AND:  res = op_a & op_b;
            ALU_OR:   res = op_a | op_b;
            ALU_XOR:  res = op_a ^ op_b;
            ALU_NOR:  res = ~(op_a | op_b);
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:  res = op_b << in_shamt;
            ALU_SRL:  res = op_b >> in_shamt;
            ALU_SRA:  res = $signed(op_b) >>> in_shamt;
            ALU_LUI:  res = op_b << (WIDTH / 2);
            ALU_MFHI: res = hi;
            ALU_MFLO: res = lo;
            default:  res = '0;
        endcase
    end

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_mul),
        .is_signed (fn == ALU_MULT),
        .a         (op_a),
        .b         (op_b),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_next = S_MUL;
            S_MUL:   if (mul_done)         state_next = S_DONE;
            S_DONE:  if (buf_free)         state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            hi           <= '0;
            lo           <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_wb_en    <= 1'b0;
            out_dest     <= '0;
        end else begin
            state <= state_next;
            if (state == S_MUL && mul_done) begin
                hi <= mul_product[2*WIDTH-1:WIDTH];
                lo <= mul_product[WIDTH-1:0];
            end
            if (accept && !is_mul) begin
                out_valid    <= 1'b1;
                out_result   <= res;
                out_zero     <= (res == '0);
                out_overflow <= ovf;
                out_wb_en    <= in_wb_en;
                out_dest     <= in_dest;
            end else if (state == S_DONE && buf_free) begin
                // multiply beat carries LO but never writes a GPR
                out_valid    <= 1'b1;
                out_result   <= lo;
                out_zero     <= (lo == '0);
                out_overflow <= 1'b0;
                out_wb_en    <= 1'b0;
                out_dest     <= '0;
            end else if (out_ready) begin
                out_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// Directed self-checking bench for execute_stage_pipelined at WIDTH=32.
module tb_execute_stage_pipelined;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs_data, in_rt_data, in_imm;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [2:0]  in_alu_op;
    logic        in_alu_src, in_wb_en;
    logic [4:0]  in_dest;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_zero, out_overflow, out_wb_en;
    logic [4:0]  out_dest;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int stall;

    execute_stage_pipelined #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_alu_op(in_alu_op),
        .in_alu_src(in_alu_src), .in_wb_en(in_wb_en), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_overflow(out_overflow), .out_wb_en(out_wb_en),
        .out_dest(out_dest), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [5:0] funct, input logic [2:0] aop, input logic src,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] sh, input logic [4:0] dest);
        in_funct   = funct;
        in_alu_op  = aop;
        in_alu_src = src;
        in_rs_data = a;
        in_rt_data = b;
        in_imm     = imm;
        in_shamt   = sh;
        in_wb_en   = 1'b1;
        in_dest    = dest;
    endtask

    // one accepted op; returns #1 after the accepting edge with in_valid dropped
    task automatic issue(input string tag, input logic [5:0] funct, input logic [2:0] aop,
                         input logic src, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] dest);
        @(negedge clk);
        set_op(funct, aop, src, a, b, imm, sh, dest);
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic z,
                           input logic ovf, input logic wb);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_zero"}, 32'(out_zero), 32'(z));
        chk({tag, "_ovf"}, 32'(out_overflow), 32'(ovf));
        chk({tag, "_wb"}, 32'(out_wb_en), 32'(wb));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op(6'h00, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_dest", 32'(out_dest), 32'd0);

        issue("add_ovf", 6'h20, 3'b010, 1'b1, 32'h7fffffff, 32'h1, 32'h0, 5'd0, 5'd5);
        chk_out("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b1);
        chk("add_ovf_dest", 32'(out_dest), 32'd5);

        issue("sub_zero", 6'h00, 3'b001, 1'b1, 32'h1234, 32'h1234, 32'h0, 5'd0, 5'd6);
        chk_out("sub_zero", 32'h0, 1'b1, 1'b0, 1'b1);

        issue("addu_wrap", 6'h21, 3'b010, 1'b1, 32'hffffffff, 32'h1, 32'h0, 5'd0, 5'd6);
        chk_out("addu_wrap", 32'h0, 1'b1, 1'b0, 1'b1);

        issue("sub_ovf", 6'h22, 3'b010, 1'b1, 32'h80000000, 32'h1, 32'h0, 5'd0, 5'd6);
        chk_out("sub_ovf", 32'h7fffffff, 1'b0, 1'b1, 1'b1);

        issue("sra", 6'h03, 3'b010, 1'b1, 32'h0, 32'h80000000, 32'h0, 5'd4, 5'd1);
        chk("sra_result", out_result, 32'hf8000000);
        issue("srl", 6'h02, 3'b010, 1'b1, 32'h0, 32'h80000000, 32'h0, 5'd4, 5'd1);
        chk("srl_result", out_result, 32'h08000000);
        issue("sll", 6'h00, 3'b010, 1'b1, 32'h0, 32'h1, 32'h0, 5'd31, 5'd1);
        chk("sll_result", out_result, 32'h80000000);

        issue("add_imm", 6'h3f, 3'b000, 1'b0, 32'h5, 32'h99, 32'hffffffff, 5'd0, 5'd2);
        chk_out("add_imm", 32'h4, 1'b0, 1'b0, 1'b1);
        issue("lui", 6'h00, 3'b110, 1'b0, 32'h0, 32'h0, 32'h1234, 5'd0, 5'd2);
        chk("lui_result", out_result, 32'h12340000);
        issue("slt", 6'h2a, 3'b010, 1'b1, 32'hffffffff, 32'h1, 32'h0, 5'd0, 5'd2);
        chk("slt_result", out_result, 32'h1);
        issue("sltu", 6'h2b, 3'b010, 1'b1, 32'hffffffff, 32'h1, 32'h0, 5'd0, 5'd2);
        chk("sltu_result", out_result, 32'h0);
        issue("nor", 6'h27, 3'b010, 1'b1, 32'hf0f0f0f0, 32'h0000ffff, 32'h0, 5'd0, 5'd2);
        chk("nor_result", out_result, 32'h0f0f0000);
        issue("op111", 6'h20, 3'b111, 1'b1, 32'h7fffffff, 32'h1, 32'h0, 5'd0, 5'd2);
        chk_out("op111", 32'h0, 1'b1, 1'b0, 1'b1);
        issue("bad_funct", 6'h3f, 3'b010, 1'b1, 32'h7fffffff, 32'h1, 32'h0, 5'd0, 5'd2);
        chk_out("bad_funct", 32'h0, 1'b1, 1'b0, 1'b1);

        // signed MULT: 32 MUL cycles plus one DONE cycle with in_ready low
        issue("mult", 6'h18, 3'b010, 1'b1, 32'hfffffffe, 32'h3, 32'h0, 5'd0, 5'd9);
        chk("mult_busy", 32'(busy), 32'd1);
        stall = 0;
        while (!in_ready && stall < 100) begin
            stall++;
            @(posedge clk);
            #1;
        end
        chk("mult_stall_cycles", 32'(stall), 32'd33);
        chk("mult_busy_after", 32'(busy), 32'd0);
        chk_out("mult_beat", 32'hfffffffa, 1'b0, 1'b0, 1'b0);
        issue("mfhi", 6'h10, 3'b010, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3);
        chk_out("mfhi", 32'hffffffff, 1'b0, 1'b0, 1'b1);
        issue("mflo", 6'h12, 3'b010, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3);
        chk("mflo_result", out_result, 32'hfffffffa);

        issue("multu", 6'h19, 3'b010, 1'b1, 32'hffffffff, 32'h2, 32'h0, 5'd0, 5'd9);
        stall = 0;
        while (!in_ready && stall < 100) begin
            stall++;
            @(posedge clk);
            #1;
        end
        chk("multu_stall_cycles", 32'(stall), 32'd33);
        chk("multu_beat", out_result, 32'hfffffffe);
        issue("mfhi_u", 6'h10, 3'b010, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3);
        chk("mfhi_u_result", out_result, 32'h1);

        // back-pressure: hold the ADD result for 5 cycles with a second op waiting
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue("bp_add", 6'h20, 3'b010, 1'b1, 32'h1, 32'h2, 32'h0, 5'd0, 5'd7);
        chk_out("bp_add", 32'h3, 1'b0, 1'b0, 1'b1);
        set_op(6'h25, 3'b010, 1'b1, 32'hf0, 32'h0f, 32'h0, 5'd0, 5'd8);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", out_result, 32'h3);
            chk("bp_hold_dest", 32'(out_dest), 32'd7);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_out("bp_second", 32'hff, 1'b0, 1'b0, 1'b1);
        chk("bp_second_dest", 32'(out_dest), 32'd8);
        @(posedge clk);
        #1;
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // reset in the middle of a multiply aborts it and clears HI/LO
        issue("mult_abort", 6'h18, 3'b010, 1'b1, 32'h5, 32'h7, 32'h0, 5'd0, 5'd9);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        issue("abort_mfhi", 6'h10, 3'b010, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3);
        chk_out("abort_mfhi", 32'h0, 1'b1, 1'b0, 1'b1);
        issue("abort_mflo", 6'h12, 3'b010, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3);
        chk("abort_mflo_result", out_result, 32'h0);
        repeat (10) @(posedge clk);
        chk("abort_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
